vid_timing_gen: RTL and testbench

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

---
 rtl/vid_timing_gen.sv | 207 ++++++++++++++++++++
 tb/tb_vid_timing_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Raster timing generator with test-pattern source.
// Free-running h/v counters feed a registered decode stage and an output flop stage (2-cycle latency).
module vid_timing_gen #(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CNT_W    = 12
) (
    input  logic             sys2_clk,
    input  logic             sys2_rst,
    input  logic             en,
    input  logic [3:0]       mode,
    input  logic [CNT_W-1:0] box_x0,
    input  logic [CNT_W-1:0] box_x1,
    input  logic [CNT_W-1:0] box_y0,
    input  logic [CNT_W-1:0] box_y1,
    input  logic [7:0]       solid_y,
    output logic             vid_de,
    output logic             vid_hs,
    output logic             vid_vs,
    output logic [15:0]      vid_data,
    output logic             sof,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int HTOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HTOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VTOT - 1);

    logic             run_q, run_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       mode_q, mode_d;
    logic [CNT_W-1:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
    logic [7:0]       solid_q, solid_d;

    logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, sof1_q, sof1_d;
    logic [7:0]       luma1_q, luma1_d;
    logic             de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d, sof2_q, sof2_d;
    logic [15:0]      data2_q, data2_d;

    logic             line_end, frame_start, in_box;
    logic [31:0]      h_ext, v_ext;
    logic [7:0]       frame_lo, bar_luma;
    logic [2:0]       bar_idx;

    assign line_end    = (hcnt_q == H_LAST);
    assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    assign h_ext       = 32'(hcnt_q);
    assign v_ext       = 32'(vcnt_q);
    assign frame_lo    = 8'(frame_cnt_q);

    // The counters only advance once en has been seen high for a full cycle,
    // so the first running cycle always presents pixel (0,0).
    always_comb begin
        run_d       = en;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        if (!en) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (run_q) begin
            if (line_end) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d      = '0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    // Pattern controls are taken live at (0,0) and held for the rest of the frame.
    always_comb begin
        mode_d  = frame_start ? mode    : mode_q;
        bx0_d   = frame_start ? box_x0  : bx0_q;
        bx1_d   = frame_start ? box_x1  : bx1_q;
        by0_d   = frame_start ? box_y0  : by0_q;
        by1_d   = frame_start ? box_y1  : by1_q;
        solid_d = frame_start ? solid_y : solid_q;
    end

    assign in_box = (bx0_d < hcnt_q) && (hcnt_q < bx1_d) &&
                    (by0_d < vcnt_q) && (vcnt_q < by1_d);

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_ext >= 32'(k * BAR_W)) bar_idx = 3'(k);
        end
        case (bar_idx)
            3'd0:    bar_luma = 8'hEB;
            3'd1:    bar_luma = 8'hD2;
            3'd2:    bar_luma = 8'hAA;
            3'd3:    bar_luma = 8'h91;
            3'd4:    bar_luma = 8'h6A;
            3'd5:    bar_luma = 8'h51;
            3'd6:    bar_luma = 8'h29;
            default: bar_luma = 8'h10;
        endcase
    end

    always_comb begin
        luma1_d = 8'h10;
        case (mode_d)
            4'h0: luma1_d = h_ext[7:0];
            4'h1: luma1_d = v_ext[7:0];
            4'h2: luma1_d = h_ext[8:1];
            4'h3: luma1_d = v_ext[8:1];
            4'h4: luma1_d = h_ext[9:2];
            4'h5: luma1_d = v_ext[9:2];
            4'h6: luma1_d = h_ext[10:3];
            4'h7: luma1_d = v_ext[10:3];
            4'h8: luma1_d = in_box ? v_ext[7:0] : h_ext[7:0];
            4'h9: luma1_d = in_box ? frame_lo : h_ext[7:0];
            4'hA: luma1_d = solid_d;
            4'hB: luma1_d = bar_luma;
            4'hC: luma1_d = (h_ext[5] ^ v_ext[5]) ? 8'h10 : 8'hEB;
            default: luma1_d = 8'h10;
        endcase
    end

    always_comb begin
        de1_d   = run_q && (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
        hs1_d   = run_q && (h_ext >= 32'(HS_START)) && (h_ext < 32'(HS_END));
        vs1_d   = run_q && (v_ext >= 32'(VS_START)) && (v_ext < 32'(VS_END));
        sof1_d  = run_q && frame_start;
        de2_d   = de1_q;
        hs2_d   = hs1_q ? HS_POL : ~HS_POL;
        vs2_d   = vs1_q ? VS_POL : ~VS_POL;
        sof2_d  = sof1_q;
        data2_d = de1_q ? {8'h80, luma1_q} : 16'h8010;
    end

    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            run_q       <= 1'b0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            mode_q      <= 4'h0;
            bx0_q       <= '0;
            bx1_q       <= '0;
            by0_q       <= '0;
            by1_q       <= '0;
            solid_q     <= 8'h00;
            de1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            sof1_q      <= 1'b0;
            luma1_q     <= 8'h10;
            de2_q       <= 1'b0;
            hs2_q       <= ~HS_POL;
            vs2_q       <= ~VS_POL;
            sof2_q      <= 1'b0;
            data2_q     <= 16'h8010;
        end else begin
            run_q       <= run_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            bx0_q       <= bx0_d;
            bx1_q       <= bx1_d;
            by0_q       <= by0_d;
            by1_q       <= by1_d;
            solid_q     <= solid_d;
            de1_q       <= de1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            sof1_q      <= sof1_d;
            luma1_q     <= luma1_d;
            de2_q       <= de2_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
            sof2_q      <= sof2_d;
            data2_q     <= data2_d;
        end
    end

    assign vid_de    = de2_q;
    assign vid_hs    = hs2_q;
    assign vid_vs    = vs2_q;
    assign vid_data  = data2_q;
    assign sof       = sof2_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a small raster with active-low syncs: pixel vector table,
// hand sequences for mode change / reset / enable, and a randomized run against a raster model.
module tb_vid_timing_gen;

    localparam int HA = 64, HF = 2, HSY = 4, HB = 2, HT = HA + HF + HSY + HB;
    localparam int VA = 34, VF = 1, VSY = 2, VB = 1, VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam int CW = 12;
    localparam logic [19:0] IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 16'h8010};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [3:0]    mode = 4'h0;
    logic [CW-1:0] box_x0 = '0, box_x1 = '0, box_y0 = '0, box_y1 = '0;
    logic [7:0]    solid_y = 8'h00;
    logic          vid_de, vid_hs, vid_vs, sof;
    logic [15:0]   vid_data;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    vid_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) dut (
        .sys2_clk(clk), .sys2_rst(rst), .en(en), .mode(mode),
        .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
        .solid_y(solid_y), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
        .vid_data(vid_data), .sof(sof), .frame_cnt(frame_cnt)
    );

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the raster is a linear pixel index p since the run started;
    // x/y/frame come from division and remainder by the line and frame sizes.
    int m_run, m_p, m_frames, mx, my;
    int c_mode, c_x0, c_x1, c_y0, c_y1, c_sy;
    logic [19:0] m_s1, m_out;
    logic m_de, m_hs, m_vs;
    logic [7:0] m_luma;

    function automatic logic [7:0] ref_luma(input int x, input int y);
        logic [7:0] bars [8];
        bit inb;
        int idx;
        bars = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};
        inb = (c_x0 < x) && (x < c_x1) && (c_y0 < y) && (y < c_y1);
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        case (c_mode)
            0: return 8'(x % 256);
            1: return 8'(y % 256);
            2: return 8'((x / 2) % 256);
            3: return 8'((y / 2) % 256);
            4: return 8'((x / 4) % 256);
            5: return 8'((y / 4) % 256);
            6: return 8'((x / 8) % 256);
            7: return 8'((y / 8) % 256);
            8: return inb ? 8'(y % 256) : 8'(x % 256);
            9: return inb ? 8'(m_frames % 256) : 8'(x % 256);
            10: return 8'(c_sy);
            11: return bars[idx];
            12: return (((x / 32) + (y / 32)) % 2 == 1) ? 8'h10 : 8'hEB;
            default: return 8'h10;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_p = 0; m_frames = 0; c_mode = 0;
            m_s1 = IDLE; m_out = IDLE;
        end else begin
            m_out = m_s1;
            if (m_run != 0) begin
                mx = m_p % HT;
                my = (m_p / HT) % VT;
                if (m_p % FT == 0) begin
                    c_mode = int'(mode); c_sy = int'(solid_y);
                    c_x0 = int'(box_x0); c_x1 = int'(box_x1);
                    c_y0 = int'(box_y0); c_y1 = int'(box_y1);
                end
                m_de = (mx < HA) && (my < VA);
                m_hs = !((mx >= HA + HF) && (mx < HA + HF + HSY));
                m_vs = !((my >= VA + VF) && (my < VA + VF + VSY));
                m_luma = ref_luma(mx, my);
                m_s1 = {m_de, m_hs, m_vs, (m_p % FT == 0), m_de ? {8'h80, m_luma} : 16'h8010};
            end else begin
                m_s1 = IDLE;
            end
            if (m_run != 0 && en) begin
                if (m_p % FT == FT - 1) m_frames++;
                m_p++;
            end else begin
                m_p = 0;
            end
            m_run = en ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on)
            chk("model", {vid_de, vid_hs, vid_vs, sof, vid_data, frame_cnt},
                {m_out, 12'(m_frames)});
    end

    task automatic wait_sof(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!sof && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sof), 64'd1);
    endtask

    task automatic cycles_to_sof(input string tag, input int want);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sof && n < 2 * FT);
        chk(tag, 64'(n), 64'(want));
    endtask

    task automatic set_cfg(input logic [3:0] md, input int x0, input int x1, input int y0,
                           input int y1, input logic [7:0] sy);
        mode = md; solid_y = sy;
        box_x0 = CW'(x0); box_x1 = CW'(x1); box_y0 = CW'(y0); box_y1 = CW'(y1);
    endtask

    typedef struct {
        logic [3:0]  md;
        int          bx0, bx1, by0, by1;
        logic [7:0]  sy;
        int          x, y;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [16];
    int fr_hold, r;

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'h0, 0, 0, 0, 0, 8'h00, 5, 0, 16'h8005};
        vecs[1]  = '{4'h0, 0, 0, 0, 0, 8'h00, 67, 0, 16'h8010};
        vecs[2]  = '{4'h1, 0, 0, 0, 0, 8'h00, 3, 7, 16'h8007};
        vecs[3]  = '{4'h2, 0, 0, 0, 0, 8'h00, 9, 0, 16'h8004};
        vecs[4]  = '{4'h4, 0, 0, 0, 0, 8'h00, 40, 2, 16'h800A};
        vecs[5]  = '{4'h7, 0, 0, 0, 0, 8'h00, 10, 33, 16'h8004};
        vecs[6]  = '{4'hB, 0, 0, 0, 0, 8'h00, 0, 0, 16'h80EB};
        vecs[7]  = '{4'hB, 0, 0, 0, 0, 8'h00, 20, 1, 16'h80AA};
        vecs[8]  = '{4'hB, 0, 0, 0, 0, 8'h00, 63, 3, 16'h8010};
        vecs[9]  = '{4'hC, 0, 0, 0, 0, 8'h00, 32, 0, 16'h8010};
        vecs[10] = '{4'hC, 0, 0, 0, 0, 8'h00, 32, 32, 16'h80EB};
        vecs[11] = '{4'h8, 10, 20, 10, 20, 8'h00, 15, 12, 16'h800C};
        vecs[12] = '{4'h8, 10, 20, 10, 20, 8'h00, 10, 12, 16'h800A};
        vecs[13] = '{4'h8, 15, 15, 10, 20, 8'h00, 15, 12, 16'h800F};
        vecs[14] = '{4'hA, 0, 0, 0, 0, 8'h55, 7, 7, 16'h8055};
        vecs[15] = '{4'hD, 0, 0, 0, 0, 8'h00, 7, 7, 16'h8010};

        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_state", {vid_de, vid_hs, vid_vs, sof, vid_data, frame_cnt},
            {1'b0, 1'b1, 1'b1, 1'b0, 16'h8010, 12'h000});
        rst = 1'b0;
        en = 1'b1;
        cycles_to_sof("start_latency", 3);

        for (int i = 0; i < 16; i++) begin
            set_cfg(vecs[i].md, vecs[i].bx0, vecs[i].bx1, vecs[i].by0, vecs[i].by1, vecs[i].sy);
            wait_sof($sformatf("vec%0d_sof", i));
            repeat (vecs[i].y * HT + vecs[i].x) @(negedge clk);
            chk($sformatf("vec%0d_data", i), 64'(vid_data), 64'(vecs[i].exp));
        end

        // Mode switch mid-frame only takes effect at the next frame.
        set_cfg(4'h0, 0, 0, 0, 0, 8'h00);
        wait_sof("mc_sof0");
        wait_sof("mc_sof1");
        chk("mc_first_px", 64'(vid_data), 64'h8000);
        repeat (10 * HT + 20) @(negedge clk);
        chk("mc_before", 64'(vid_data), 64'h8014);
        mode = 4'hB;
        repeat (10 * HT) @(negedge clk);
        chk("mc_same_frame", 64'(vid_data), 64'h8014);
        wait_sof("mc_sof2");
        chk("mc_bar0", 64'(vid_data), 64'h80EB);
        repeat (20 * HT + 20) @(negedge clk);
        chk("mc_bar2", 64'(vid_data), 64'h80AA);
        repeat (43) @(negedge clk);
        chk("mc_bar7", 64'(vid_data), 64'h8010);

        // Reset mid-frame while hsync is active.
        wait_sof("rst_sof");
        repeat (5 * HT + 67) @(negedge clk);
        chk("rst_pre_hs", 64'(vid_hs), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out", {vid_de, vid_hs, vid_vs, sof, vid_data, frame_cnt},
            {1'b0, 1'b1, 1'b1, 1'b0, 16'h8010, 12'h000});
        rst = 1'b0;
        cycles_to_sof("rst_restart", 3);

        // Enable dropped mid-line.
        wait_sof("en_sof");
        repeat (HT + 30) @(negedge clk);
        fr_hold = m_frames;
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_idle", {vid_de, vid_hs, vid_vs, sof, vid_data, frame_cnt},
            {IDLE, 12'(fr_hold)});
        en = 1'b1;
        cycles_to_sof("en_restart", 3);
        chk("en_frame_hold", 64'(frame_cnt), 64'(fr_hold));

        // Randomized run: config changes, enable gaps and reset pulses, all checked by the model.
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 999);
            rst = 1'b0;
            if (r < 4)
                set_cfg(4'($urandom_range(0, 15)), $urandom_range(0, 70), $urandom_range(0, 70),
                        $urandom_range(0, 40), $urandom_range(0, 40), 8'($urandom));
            if (r == 5 && en) en = 1'b0;
            else if (!en && r < 150) en = 1'b1;
            if (r == 7) rst = 1'b1;
        end
        rst = 1'b0;
        en = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
